usb_tx_encoder: RTL

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_tx_encoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: bytes in (valid/ready, one-byte holding register) -> NRZI, bit-stuffed D+/D- with EOP.
// Define SYNC_GEN_EN to emit the SYNC byte internally; otherwise the caller's first byte is sent as-is.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx, hold_dat, src_dat;
  logic [2:0]    bit_idx, bit_idx_nx, ones, ones_nx;
  logic          hold_full, hold_last, cur_last, cur_last_nx;
  logic          line_j, line_j_nx, se0, se0_nx, eop_cnt, eop_cnt_nx;
  logic          done_nx, err_nx;
  logic          accept, consume, bit_end, src_avail, src_last, emit, emit_bit;

  assign tx_ready  = !hold_full && (state != EOP_SE0) && (state != EOP_J);
  assign accept    = tx_valid && tx_ready;
  assign bit_end   = (bit_cnt == TW'(CLKS_PER_BIT - 1));
  // A byte offered on the very boundary cycle bypasses the holding register.
  assign src_avail = hold_full || accept;
  assign src_dat   = hold_full ? hold_dat : tx_data;
  assign src_last  = hold_full ? hold_last : tx_last;

  assign d_plus  = !se0 && line_j;
  assign d_minus = !se0 && !line_j;
  assign tx_busy = (state != IDLE);

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_idx_nx  = bit_idx;
    ones_nx     = ones;
    line_j_nx   = line_j;
    se0_nx      = se0;
    eop_cnt_nx  = eop_cnt;
    cur_last_nx = cur_last;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    consume     = 1'b0;
    emit        = 1'b0;
    emit_bit    = 1'b0;
    bit_cnt_nx  = (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (src_avail) begin
`ifdef SYNC_GEN_EN
          state_nx    = SYNC;
          shreg_nx    = 8'h80;
          cur_last_nx = 1'b0;
`else
          state_nx    = DATA;
          shreg_nx    = src_dat;
          cur_last_nx = src_last;
          consume     = 1'b1;
`endif
          bit_idx_nx = '0;
          emit       = 1'b1;
          emit_bit   = shreg_nx[0];
        end
      end
      SYNC, DATA: begin
        if (bit_end) begin
          // Stuffing takes priority, so a stuff bit after the final data bit precedes EOP.
          if (ones == 3'd6) begin
            emit     = 1'b1;
            emit_bit = 1'b0;
          end else if (bit_idx != 3'd7) begin
            bit_idx_nx = bit_idx + 3'd1;
            emit       = 1'b1;
            emit_bit   = shreg[bit_idx_nx];
          end else if (cur_last) begin
            state_nx   = EOP_SE0;
            se0_nx     = 1'b1;
            eop_cnt_nx = 1'b0;
            ones_nx    = '0;
          end else if (src_avail) begin
            state_nx    = DATA;
            shreg_nx    = src_dat;
            cur_last_nx = src_last;
            consume     = 1'b1;
            bit_idx_nx  = '0;
            emit        = 1'b1;
            emit_bit    = src_dat[0];
          end else begin
            state_nx   = EOP_SE0;
            se0_nx     = 1'b1;
            eop_cnt_nx = 1'b0;
            ones_nx    = '0;
            err_nx     = 1'b1;
          end
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (eop_cnt) begin
            state_nx  = EOP_J;
            se0_nx    = 1'b0;
            line_j_nx = 1'b1;
          end else begin
            eop_cnt_nx = 1'b1;
          end
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (emit) begin
      line_j_nx = emit_bit ? line_j : !line_j;
      ones_nx   = emit_bit ? ones + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      ones      <= '0;
      line_j    <= 1'b1;
      se0       <= 1'b0;
      eop_cnt   <= 1'b0;
      cur_last  <= 1'b0;
      hold_full <= 1'b0;
      hold_dat  <= '0;
      hold_last <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      bit_idx  <= bit_idx_nx;
      ones     <= ones_nx;
      line_j   <= line_j_nx;
      se0      <= se0_nx;
      eop_cnt  <= eop_cnt_nx;
      cur_last <= cur_last_nx;
      tx_done  <= done_nx;
      tx_err   <= err_nx;
      if (accept && !consume) begin
        hold_full <= 1'b1;
        hold_dat  <= tx_data;
        hold_last <= tx_last;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
